// File: rtl/hamming_serial_decoder.sv
// Serial Hamming decoder: shifts in a W-bit frame LSB first, then computes the
// syndrome, corrects single errors (SECDED optionally detects doubles) and holds the results.
module hamming_serial_decoder #(
  parameter int R      = 3,
  parameter int SECDED = 0,
  localparam int N     = (1 << R) - 1,
  localparam int K     = N - R,
  localparam int W     = N + SECDED
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dataIncoming,
  input  logic         dataIn,
  output logic [W-1:0] currentData,
  output logic [K-1:0] dataOut,
  output logic [R-1:0] parity,
  output logic         errorFound,
  output logic         errorCorrected,
  output logic         uncorrectable,
  output logic         done,
  output logic         busy,
  output logic         overrun,
  output logic [1:0]   state
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   frame;
  logic [CW-1:0]  count;
  logic [R-1:0]   syndrome;
  logic           overall;
  logic [W-1:0]   fixed;
  logic [K-1:0]   data_bits;
  logic           fix, bad;

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dataIncoming) state_d = SHIFT;
      SHIFT:   if (dataIncoming && count == CW'(W - 1)) state_d = CHECK;
      CHECK:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    overrun = dataIncoming && (state_q == CHECK || state_q == DONE);
    state   = state_q;
  end

  // The count is back at zero in IDLE, so the IDLE bit lands at index 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame <= '0;
      count <= '0;
    end else if (dataIncoming && (state_q == IDLE || state_q == SHIFT)) begin
      frame[count] <= dataIn;
      count        <= (count == CW'(W - 1)) ? '0 : count + CW'(1);
    end
  end

  always_comb begin
    syndrome = '0;
    overall  = 1'b0;
    for (int i = 0; i < N; i++)
      if (frame[i]) syndrome = syndrome ^ R'(i + 1);
    for (int i = 0; i < W; i++)
      overall = overall ^ frame[i];

    fix = 1'b0;
    bad = 1'b0;
    if (SECDED != 0) begin
      if (syndrome != '0 && !overall) bad = 1'b1;
      else if (overall)               fix = 1'b1;
    end else begin
      fix = (syndrome != '0);
    end

    fixed = frame;
    if (fix) begin
      if (syndrome == '0) begin
        if (SECDED != 0) fixed[W-1] = ~fixed[W-1];
      end else begin
        for (int i = 0; i < N; i++)
          if (syndrome == R'(i + 1)) fixed[i] = ~fixed[i];
      end
    end

    // Data bits occupy the non-power-of-two positions, packed in ascending order.
    data_bits = '0;
    begin
      int k;
      k = 0;
      for (int p = 1; p <= N; p++) begin
        if ((p & (p - 1)) != 0) begin
          data_bits[k] = fixed[p-1];
          k++;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      currentData    <= '0;
      dataOut        <= '0;
      parity         <= '0;
      errorFound     <= 1'b0;
      errorCorrected <= 1'b0;
      uncorrectable  <= 1'b0;
    end else if (state_q == CHECK) begin
      currentData    <= fixed;
      dataOut        <= data_bits;
      parity         <= syndrome;
      errorFound     <= fix | bad;
      errorCorrected <= fix;
      uncorrectable  <= bad;
    end
  end

endmodule

// File: doc/hamming_serial_decoder.md
HAMMING_SERIAL_DECODER -- requirements
Module: hamming_serial_decoder

Interface
REQ-001 Parameter R, default 3, number of Hamming check bits; legal range 2..6; N = 2^R-1 codeword bits, K = N-R data bits.
REQ-002 Parameter SECDED, default 0; 1 adds an overall-parity bit, so the frame width is W = N+SECDED.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dataIncoming  in  1  serial bit valid qualifier.
REQ-006 dataIn  in  1  serial codeword bit, sampled when dataIncoming=1.
REQ-007 currentData  out  W  corrected codeword; bit i = Hamming position i+1; bit N = overall parity when SECDED=1.
REQ-008 dataOut  out  K  data bits taken from the non-power-of-two positions of currentData, in ascending position order into dataOut[0..K-1].
REQ-009 parity  out  R  syndrome of the received frame.
REQ-010 errorFound  out  1  received frame contained an error.
REQ-011 errorCorrected  out  1  a single-bit error was corrected.
REQ-012 uncorrectable  out  1  double error detected; held at 0 when SECDED=0.
REQ-013 done  out  1  one-cycle pulse when the results update.
REQ-014 busy  out  1  high in states SHIFT, CHECK and DONE.
REQ-015 overrun  out  1  one-cycle pulse when a bit is dropped.

Function
REQ-016 FSM states: IDLE, SHIFT, CHECK, DONE.
REQ-017 IDLE: when dataIncoming=1, store the bit at index 0 and go to SHIFT.
REQ-018 SHIFT: when dataIncoming=1, store the bit at the next index (LSB first).
REQ-019 SHIFT: when dataIncoming=0, hold state and bit count; gaps of any length are legal; there is no timeout.
REQ-020 SHIFT: the edge that stores bit index W-1 moves the FSM to CHECK.
REQ-021 CHECK: compute the syndrome as the XOR of the positions (index+1) of all 1 bits in indices 0..N-1; compute overall parity P as the XOR of all W bits.
REQ-022 CHECK -> DONE: the edge leaving CHECK registers all result outputs and sets done=1.
REQ-023 DONE -> IDLE: done returns to 0.
REQ-024 Latency: done is high in the 2nd cycle after the edge that samples the last bit.
REQ-025 Result outputs change only on the done edge; they hold until the next done.
REQ-026 Classification, SECDED=0:
 - syndrome 0: no error, all flags 0.
 - syndrome s≠0: flip bit s-1; errorFound=1, errorCorrected=1.
REQ-027 Classification, SECDED=1:
 - syndrome 0, P=0: no error.
 - syndrome s≠0, P=1: flip bit s-1; errorFound=1, errorCorrected=1.
 - syndrome 0, P=1: flip bit N; errorFound=1, errorCorrected=1.
 - syndrome ≠0, P=0: errorFound=1, uncorrectable=1, errorCorrected=0; currentData is the raw frame.
REQ-028 The parity output always carries the raw syndrome.
REQ-029 dataIncoming=1 in CHECK or DONE: the bit is discarded and overrun pulses for 1 cycle; the next frame starts only from IDLE.
REQ-030 Flags are mutually consistent: errorCorrected and uncorrectable are never both 1.

Reset
REQ-031 reset=1 at a clock edge forces IDLE, clears the bit count and shift register, and drives every output to 0, including mid-frame and in CHECK/DONE.
REQ-032 reset has priority over dataIncoming; a bit presented with reset is discarded.
REQ-033 After reset deasserts, the first dataIncoming=1 bit is index 0.

Verification (R=3 unless noted)
REQ-034 Clean frame: serialize 7'b1100110 LSB first -> currentData=7'b1100110, dataOut=4'b1101, parity=0, all flags 0, done 2 cycles after the last bit.
REQ-035 Single error: send 7'b1110110 -> parity=3'b101, currentData=7'b1100110, errorFound=1, errorCorrected=1.
REQ-036 SECDED=1 double error: send 8'b01010110 -> parity=3'b011, uncorrectable=1, currentData=8'b01010110; parity-bit-only error 8'b11100110 -> currentData=8'b01100110, errorCorrected=1.
REQ-037 Gapped input plus reset: insert 3-cycle dataIncoming=0 gaps in the clean frame -> identical result; assert reset after bit 4 -> outputs 0, and the next 7 bits decode correctly.
REQ-038 Overrun: hold dataIncoming=1 continuously for 9 cycles -> overrun pulses in CHECK and DONE, done pulses once, and bit 10 starts a new frame.
REQ-039 Sweep R=2..6: random single-bit errors are always corrected; random double errors with SECDED=1 always set uncorrectable.
